lock_ctrl: RTL and testbench

Front-end controller for the 4-digit keypad lock (`lock4`). It shares the lock's single key port between two keypads (A and B) using round-robin sessions. It forwards the owning keypad's keys to the lock with one-cycle latency and releases idle sessions on timeout. It counts failed unlock attempts and blocks both keypads for a fixed lockout period after `MAX_FAIL` consecutive failures.

---
 rtl/lock_pkg.sv | 50 +++++
 rtl/lock_timer.sv | 43 ++++
 rtl/lock_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_lock_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lock front-end controller.
// The key codes match the lock4 command set; the helpers keep key decoding
// and timer sizing in one place so the controller and timer agree.
package lock_pkg;

  // Controller phases: free, owned by one keypad, waiting on the lock's
  // verdict, or blocked after too many failed attempts.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OWN_A   = 3'd1,
    ST_OWN_B   = 3'd2,
    ST_CHECK   = 3'd3,
    ST_LOCKOUT = 3'd4
  } ctrl_state_t;

  // What a forwarded owner key means for the session.
  typedef enum logic [1:0] {
    KC_DATA  = 2'd0,   // digit or command handled entirely by the lock
    KC_ENTER = 2'd1,   // ends the session and triggers a verdict check
    KC_LOCK  = 2'd2    // ends the session without a verdict
  } key_class_t;

  // Lock command keys.
  localparam logic [3:0] KEY_LOCK  = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;
  localparam logic [3:0] KEY_CHPW  = 4'hE;

  // Keypad selectors used for ownership and round-robin priority.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Integer maximum, used to size the shared timer for both phases.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Classify an owner key. Change-password is a multi-key lock command,
  // so from the controller's point of view it keeps the session open.
  function automatic key_class_t classify_key(input logic [3:0] key);
    key_class_t cls;
    case (key)
      KEY_ENTER: cls = KC_ENTER;
      KEY_LOCK:  cls = KC_LOCK;
      KEY_CHPW:  cls = KC_DATA;
      default:   cls = KC_DATA;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Programmable up-counter shared by the idle-timeout and lockout phases.
// clr_i wins over en_i. last_o flags that the current cycle is the final
// one of a limit_i-cycle window, so the owner can leave on that edge.
module lock_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear has priority, otherwise advance when enabled.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == limit_i - 1'b1);

endmodule

// File: rtl/lock_ctrl.sv
// Front-end controller sharing lock4's single key port between keypads A
// and B. Sessions are granted round-robin, owner keys are forwarded through
// a one-cycle register stage, idle sessions time out, and repeated failed
// unlock attempts put both keypads into a timed lockout.
module lock_ctrl
  import lock_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [3:0]                    key_a,
  input  logic                          valid_a,
  input  logic [3:0]                    key_b,
  input  logic                          valid_b,
  input  logic                          lock_state,
  output logic [3:0]                    key_out,
  output logic                          valid_out,
  output logic                          grant_a,
  output logic                          grant_b,
  output logic                          lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int TMR_W  = $clog2(max_int(TIMEOUT_CYC, LOCKOUT_CYC) + 1);

  localparam logic [FAIL_W-1:0] FAIL_MAX    = FAIL_W'(MAX_FAIL);
  localparam logic [TMR_W-1:0]  TIMEOUT_LIM = TMR_W'(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0]  LOCKOUT_LIM = TMR_W'(LOCKOUT_CYC);

  ctrl_state_t       state_q, state_d;
  logic              owner_q, owner_d;     // keypad holding the session
  logic              prio_q,  prio_d;      // winner of simultaneous strobes
  logic              chk_q,   chk_d;       // 0: verdict cycle 1, 1: cycle 2
  logic [FAIL_W-1:0] fail_q,  fail_d;
  logic [3:0]        key_out_q, key_out_d;
  logic              valid_out_q, valid_out_d;

  logic              tmr_clr;
  logic              tmr_en;
  logic [TMR_W-1:0]  tmr_limit;
  logic              tmr_last;

  logic              own_valid;
  logic [3:0]        own_key;
  logic              win_b;
  logic [FAIL_W-1:0] fail_inc;

  // Select the owner's keypad and resolve who wins an idle-time strobe.
  always_comb begin
    own_valid = (owner_q == SEL_B) ? valid_b : valid_a;
    own_key   = (owner_q == SEL_B) ? key_b   : key_a;
    win_b     = valid_b && (!valid_a || (prio_q == SEL_B));
    fail_inc  = (fail_q == FAIL_MAX) ? fail_q : fail_q + 1'b1;
  end

  // Session FSM, key forwarding and fail accounting.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    prio_d      = prio_q;
    chk_d       = chk_q;
    fail_d      = fail_q;
    key_out_d   = key_out_q;
    valid_out_d = 1'b0;
    tmr_clr     = 1'b1;
    tmr_en      = 1'b0;
    tmr_limit   = TIMEOUT_LIM;

    case (state_q)
      ST_IDLE: begin
        // The losing keypad's key is simply dropped.
        if (valid_a || valid_b) begin
          owner_d     = win_b;
          key_out_d   = win_b ? key_b : key_a;
          valid_out_d = 1'b1;
          state_d     = win_b ? ST_OWN_B : ST_OWN_A;
        end
      end

      ST_OWN_A, ST_OWN_B: begin
        tmr_limit = TIMEOUT_LIM;
        if (own_valid) begin
          // Any owner activity restarts the idle window.
          key_out_d   = own_key;
          valid_out_d = 1'b1;
          case (classify_key(own_key))
            KC_ENTER: begin
              state_d = ST_CHECK;
              chk_d   = 1'b0;
            end
            KC_LOCK: begin
              state_d = ST_IDLE;
              prio_d  = ~owner_q;
            end
            default: ;
          endcase
        end else begin
          tmr_clr = 1'b0;
          tmr_en  = 1'b1;
          if (tmr_last) begin
            state_d = ST_IDLE;
            prio_d  = ~owner_q;
          end
        end
      end

      ST_CHECK: begin
        // First cycle lets the lock consume ENTER; the second samples its
        // verdict. Keypad input is ignored throughout.
        if (!chk_q) begin
          chk_d = 1'b1;
        end else begin
          chk_d  = 1'b0;
          prio_d = ~owner_q;
          if (!lock_state) begin
            fail_d  = '0;
            state_d = ST_IDLE;
          end else begin
            fail_d  = fail_inc;
            state_d = (fail_inc == FAIL_MAX) ? ST_LOCKOUT : ST_IDLE;
          end
        end
      end

      ST_LOCKOUT: begin
        // Timer was cleared during CHECK, so the window starts at zero.
        tmr_clr   = 1'b0;
        tmr_en    = 1'b1;
        tmr_limit = LOCKOUT_LIM;
        if (tmr_last) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller registers; reset drops any pending forwarded key.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      owner_q     <= SEL_A;
      prio_q      <= SEL_A;
      chk_q       <= 1'b0;
      fail_q      <= '0;
      key_out_q   <= 4'h0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      chk_q       <= chk_d;
      fail_q      <= fail_d;
      key_out_q   <= key_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  lock_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i (tmr_limit),
    .last_o  (tmr_last)
  );

  assign key_out   = key_out_q;
  assign valid_out = valid_out_q;
  assign grant_a   = (state_q == ST_OWN_A) ||
                     ((state_q == ST_CHECK) && (owner_q == SEL_A));
  assign grant_b   = (state_q == ST_OWN_B) ||
                     ((state_q == ST_CHECK) && (owner_q == SEL_B));
  assign lockout   = (state_q == ST_LOCKOUT);
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Self-checking bench for lock_ctrl. A behavioural model tracks who owns
// the port, remaining check/lockout time and the fail count, and predicts
// every output after each rising edge. Outputs are compared at the falling
// edge, where inputs are also driven.
module tb_lock_ctrl;

  localparam int TO = 16;
  localparam int MF = 3;
  localparam int LO = 32;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] key_a, key_b;
  logic       valid_a, valid_b, lock_state;
  logic [3:0] key_out;
  logic       valid_out, grant_a, grant_b, lockout;
  logic [1:0] fail_cnt;
  logic [9:0] dut_vec;

  int errors = 0;
  int checks = 0;

  // Model state: owner 0=none 1=A 2=B; prio 1=A 2=B; chk 0/1/2 = verdict
  // phase; lock_left = lockout cycles still to run.
  int         m_owner, m_prio, m_chk, m_lock_left, m_idle, m_fail;
  logic [3:0] m_key;
  logic       m_valid;

  lock_ctrl #(.TIMEOUT_CYC(TO), .MAX_FAIL(MF), .LOCKOUT_CYC(LO)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .key_a      (key_a),
    .valid_a    (valid_a),
    .key_b      (key_b),
    .valid_b    (valid_b),
    .lock_state (lock_state),
    .key_out    (key_out),
    .valid_out  (valid_out),
    .grant_a    (grant_a),
    .grant_b    (grant_b),
    .lockout    (lockout),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  assign dut_vec = {valid_out, key_out, grant_a, grant_b, lockout, fail_cnt};

  function automatic logic [9:0] exp_vec();
    return {m_valid, m_key, (m_owner == 1), (m_owner == 2),
            (m_lock_left > 0), 2'(m_fail)};
  endfunction

  task automatic model_reset();
    m_owner = 0; m_prio = 1; m_chk = 0; m_lock_left = 0;
    m_idle = 0; m_fail = 0; m_key = 4'h0; m_valid = 1'b0;
  endtask

  // One rising edge of the reference behaviour.
  task automatic model_step(input logic va, input logic [3:0] ka,
                            input logic vb, input logic [3:0] kb,
                            input logic ls);
    logic       ov;
    logic [3:0] ok;
    m_valid = 1'b0;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fail = 0;
    end else if (m_chk == 1) begin
      m_chk = 2;
    end else if (m_chk == 2) begin
      m_chk = 0;
      if (ls) begin
        if (m_fail < MF) m_fail++;
        if (m_fail == MF) m_lock_left = LO;
      end else begin
        m_fail = 0;
      end
      m_prio  = 3 - m_owner;
      m_owner = 0;
    end else if (m_owner == 0) begin
      if (va || vb) begin
        m_owner = (va && vb) ? m_prio : (va ? 1 : 2);
        m_key   = (m_owner == 1) ? ka : kb;
        m_valid = 1'b1;
        m_idle  = 0;
      end
    end else begin
      ov = (m_owner == 1) ? va : vb;
      ok = (m_owner == 1) ? ka : kb;
      if (ov) begin
        m_key   = ok;
        m_valid = 1'b1;
        m_idle  = 0;
        if (ok == 4'hC) begin
          m_chk = 1;
        end else if (ok == 4'hB) begin
          m_prio  = 3 - m_owner;
          m_owner = 0;
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_prio  = 3 - m_owner;
          m_owner = 0;
          m_idle  = 0;
        end
      end
    end
  endtask

  // Drive inputs (caller is at a falling edge), run one rising edge, and
  // return at the following falling edge with the model updated.
  task automatic tick(input logic va, input logic [3:0] ka,
                      input logic vb, input logic [3:0] kb, input logic ls);
    valid_a = va; key_a = ka; valid_b = vb; key_b = kb; lock_state = ls;
    @(posedge clk);
    model_step(va, ka, vb, kb, ls);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0; key_a = 4'h0; key_b = 4'h0;
    lock_state = 1'b1;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  function automatic logic [3:0] rand_key();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 4'hC;
    if (r == 1) return 4'hB;
    return 4'($urandom_range(0, 9));
  endfunction

  // One owner session: five keys then the verdict cycles; the other keypad
  // strobes randomly while the session is open (those keys must be dropped).
  task automatic session(input string tag, input logic use_a,
                         input logic [19:0] keys, input logic ls);
    logic [3:0] k, ko;
    logic       vo;
    for (int i = 0; i < 5; i++) begin
      k  = keys[19-4*i -: 4];
      vo = (i > 0) && ($urandom_range(0, 1) == 1);
      ko = 4'($urandom_range(0, 15));
      if (use_a) tick(1'b1, k, vo, ko, ls);
      else       tick(vo, ko, 1'b1, k, ls);
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL %s key%0d got=%b exp=%b", tag, i, dut_vec, exp_vec());
      end
      checks++;
      tick(1'b0, 4'h0, 1'b0, 4'h0, ls);
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL %s gap%0d got=%b exp=%b", tag, i, dut_vec, exp_vec());
      end
      checks++;
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 4'h0, 1'b0, 4'h0, ls);
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL %s tail%0d got=%b exp=%b", tag, i, dut_vec, exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    rstn = 1'b0;
    #1;
    if (dut_vec !== 10'b0) begin
      errors++;
      $display("FAIL reset_values got=%b exp=%b", dut_vec, 10'b0);
    end
    checks++;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_correct_entry();
    do_reset();
    session("correct_entry", 1'b1, 20'h1234C, 1'b0);
    if (fail_cnt !== 2'd0 || grant_a !== 1'b0) begin
      errors++;
      $display("FAIL correct_end fail_cnt=%0d grant_a=%b exp 0/0", fail_cnt, grant_a);
    end
    checks++;
  endtask

  task automatic test_contention();
    logic [3:0] ka [4] = '{4'h5, 4'hB, 4'h6, 4'h0};
    logic [3:0] kb [4] = '{4'h7, 4'h0, 4'h8, 4'hB};
    logic       va [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       vb [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(va[i], ka[i], vb[i], kb[i], 1'b1);
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL contention step%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      checks++;
      tick(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL contention idle%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    tick(1'b0, 4'h0, 1'b1, 4'h1, 1'b1);
    for (int i = 1; i <= TO + 1; i++) begin
      if (i <= TO) tick(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
      else         tick(1'b1, 4'h2, 1'b0, 4'h0, 1'b1);
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL timeout idle%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      checks++;
    end
    if (grant_a !== 1'b1 || key_out !== 4'h2) begin
      errors++;
      $display("FAIL timeout_regrant grant_a=%b key_out=%h exp 1/2", grant_a, key_out);
    end
    checks++;
    tick(1'b1, 4'hB, 1'b0, 4'h0, 1'b1);
  endtask

  task automatic test_lockout();
    do_reset();
    for (int s = 0; s < MF; s++) begin
      session("lockout_sess", 1'b1, 20'h9999C, 1'b1);
      if (fail_cnt !== 2'(s + 1)) begin
        errors++;
        $display("FAIL lockout_fail%0d got=%0d exp=%0d", s, fail_cnt, s + 1);
      end
      checks++;
    end
    for (int i = 0; i < LO + 2; i++) begin
      tick(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 1'b1);
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL lockout cyc%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_recovery();
    do_reset();
    session("recovery_bad1", 1'b0, 20'h5555C, 1'b1);
    session("recovery_bad2", 1'b1, 20'h7777C, 1'b1);
    session("recovery_good", 1'b0, 20'h1234C, 1'b0);
    if (fail_cnt !== 2'd0 || lockout !== 1'b0) begin
      errors++;
      $display("FAIL recovery_end fail_cnt=%0d lockout=%b exp 0/0", fail_cnt, lockout);
    end
    checks++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      tick(($urandom_range(0, 3) == 0), rand_key(),
           ($urandom_range(0, 3) == 0), rand_key(), 1'($urandom_range(0, 1)));
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid_check();
    do_reset();
    tick(1'b1, 4'h1, 1'b0, 4'h0, 1'b1);
    tick(1'b1, 4'hC, 1'b0, 4'h0, 1'b1);
    tick(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    if (m_chk != 2 || grant_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_check_setup grant_a=%b exp=1", grant_a);
    end
    checks++;
    rstn = 1'b0;
    #1;
    model_reset();
    if (dut_vec !== 10'b0) begin
      errors++;
      $display("FAIL mid_check_async got=%b exp=%b", dut_vec, 10'b0);
    end
    checks++;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL mid_check_after%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      checks++;
    end
  endtask

  initial begin
    rstn = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0; key_a = 4'h0; key_b = 4'h0;
    lock_state = 1'b1;
    model_reset();
    test_reset();
    test_correct_entry();
    test_contention();
    test_timeout();
    test_lockout();
    test_recovery();
    test_random();
    test_reset_mid_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
